// File: rtl/npu_act_mem_wr_resp.sv
// Two-requester write arbiter in front of the activation BRAM write port.
// One grant per two cycles; hw has priority unless the host has waited too long.
module npu_act_mem_wr_resp #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int MEM_DEPTH         = 3968,
  parameter int HOST_STARVE_LIMIT = 16,
  parameter int WR_CNT_WIDTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hw_mem_wr,
  input  logic [ADDR_WIDTH-1:0]   hw_mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]   hw_mem_wr_data,
  output logic                    hw_mem_wr_ack_p,
  input  logic                    host_mem_wr,
  input  logic [ADDR_WIDTH-1:0]   host_mem_wr_addr,
  input  logic [DATA_WIDTH-1:0]   host_mem_wr_data,
  output logic                    host_mem_wr_ack_p,
  output logic                    act_mem_we,
  output logic [ADDR_WIDTH-1:0]   act_mem_addr,
  output logic [DATA_WIDTH-1:0]   act_mem_wdata,
  input  logic                    wr_cnt_clr,
  output logic [WR_CNT_WIDTH-1:0] wr_cnt,
  output logic                    addr_err
);

  localparam int                  SW       = $clog2(HOST_STARVE_LIMIT + 1);
  localparam logic [SW-1:0]       LP_LIMIT = SW'(HOST_STARVE_LIMIT);
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = MEM_DEPTH[ADDR_WIDTH:0];

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t                  r_state;
  logic [SW-1:0]           r_starve;
  logic                    r_hw_ack;
  logic                    r_host_ack;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_addr_err;
  logic [WR_CNT_WIDTH-1:0] r_wr_cnt;

  logic                    w_idle;
  logic                    w_host_win;
  logic                    w_grant;
  logic                    w_in_range;
  logic [ADDR_WIDTH-1:0]   w_gnt_addr;
  logic [DATA_WIDTH-1:0]   w_gnt_data;

  assign w_idle     = (r_state == S_IDLE);
  assign w_host_win = host_mem_wr && (!hw_mem_wr || (r_starve == LP_LIMIT));
  assign w_grant    = w_idle && (hw_mem_wr || host_mem_wr);
  assign w_gnt_addr = w_host_win ? host_mem_wr_addr : hw_mem_wr_addr;
  assign w_gnt_data = w_host_win ? host_mem_wr_data : hw_mem_wr_data;
  assign w_in_range = ({1'b0, w_gnt_addr} < LP_DEPTH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_starve   <= '0;
      r_hw_ack   <= 1'b0;
      r_host_ack <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_addr_err <= 1'b0;
      r_wr_cnt   <= '0;
    end else begin
      r_hw_ack   <= 1'b0;
      r_host_ack <= 1'b0;
      r_we       <= 1'b0;
      case (r_state)
        S_IDLE: if (w_grant) begin
          r_state    <= S_ACK;
          r_hw_ack   <= !w_host_win;
          r_host_ack <= w_host_win;
          r_we       <= w_in_range;
          r_addr     <= w_gnt_addr;
          r_data     <= w_gnt_data;
          if (!w_in_range) r_addr_err <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
      // Every cycle the host is held without a grant counts as waiting, ACK cycles included.
      if (!host_mem_wr || (w_grant && w_host_win))
        r_starve <= '0;
      else if (r_starve != LP_LIMIT)
        r_starve <= r_starve + SW'(1);
      if (wr_cnt_clr)
        r_wr_cnt <= '0;
      else if (r_we)
        r_wr_cnt <= r_wr_cnt + WR_CNT_WIDTH'(1);
    end
  end

  // Reset during the ACK cycle suppresses the pulse already sitting in the flops.
  assign hw_mem_wr_ack_p   = r_hw_ack & ~rst;
  assign host_mem_wr_ack_p = r_host_ack & ~rst;
  assign act_mem_we        = r_we & ~rst;
  assign act_mem_addr      = r_addr;
  assign act_mem_wdata     = r_data;
  assign wr_cnt            = r_wr_cnt;
  assign addr_err          = r_addr_err;

endmodule

// File: tb/tb_npu_act_mem_wr_resp.sv
// Scoreboard bench for npu_act_mem_wr_resp: stimulus pushes expected grants,
// a negedge monitor pops and compares on every ack pulse.
module tb_npu_act_mem_wr_resp;

  localparam int LIMIT = 16;

  logic        clk;
  logic        rst;
  logic        hw_mem_wr, host_mem_wr, wr_cnt_clr;
  logic [11:0] hw_mem_wr_addr, host_mem_wr_addr;
  logic [7:0]  hw_mem_wr_data, host_mem_wr_data;
  logic        hw_mem_wr_ack_p, host_mem_wr_ack_p, act_mem_we, addr_err;
  logic [11:0] act_mem_addr;
  logic [7:0]  act_mem_wdata;
  logic [15:0] wr_cnt;

  // narrow-counter instance keeps the wrap scenario short
  logic        w_hw, w_hw_ack, w_host_ack, w_we, w_err;
  logic [11:0] w_addr;
  logic [7:0]  w_data;
  logic [3:0]  w_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          host;
    logic [11:0] addr;
    logic [7:0]  data;
    bit          we;
  } exp_t;
  exp_t sb_q[$];

  npu_act_mem_wr_resp u_dut (
    .clk(clk), .rst(rst),
    .hw_mem_wr(hw_mem_wr), .hw_mem_wr_addr(hw_mem_wr_addr), .hw_mem_wr_data(hw_mem_wr_data),
    .hw_mem_wr_ack_p(hw_mem_wr_ack_p),
    .host_mem_wr(host_mem_wr), .host_mem_wr_addr(host_mem_wr_addr), .host_mem_wr_data(host_mem_wr_data),
    .host_mem_wr_ack_p(host_mem_wr_ack_p),
    .act_mem_we(act_mem_we), .act_mem_addr(act_mem_addr), .act_mem_wdata(act_mem_wdata),
    .wr_cnt_clr(wr_cnt_clr), .wr_cnt(wr_cnt), .addr_err(addr_err)
  );

  npu_act_mem_wr_resp #(.WR_CNT_WIDTH(4)) u_wrap (
    .clk(clk), .rst(rst),
    .hw_mem_wr(w_hw), .hw_mem_wr_addr(12'h001), .hw_mem_wr_data(8'h01),
    .hw_mem_wr_ack_p(w_hw_ack),
    .host_mem_wr(1'b0), .host_mem_wr_addr(12'h000), .host_mem_wr_data(8'h00),
    .host_mem_wr_ack_p(w_host_ack),
    .act_mem_we(w_we), .act_mem_addr(w_addr), .act_mem_wdata(w_data),
    .wr_cnt_clr(1'b0), .wr_cnt(w_cnt), .addr_err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (hw_mem_wr_ack_p || host_mem_wr_ack_p) begin
      check("ack_exclusive", {31'd0, hw_mem_wr_ack_p & host_mem_wr_ack_p}, 0);
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {30'd0, hw_mem_wr_ack_p, host_mem_wr_ack_p}, 0);
      end else begin
        e = sb_q.pop_front();
        check("ack_source", {31'd0, host_mem_wr_ack_p}, {31'd0, e.host});
        check("mem_we",     {31'd0, act_mem_we}, {31'd0, e.we});
        check("mem_addr",   {20'd0, act_mem_addr}, {20'd0, e.addr});
        check("mem_wdata",  {24'd0, act_mem_wdata}, {24'd0, e.data});
      end
    end else if (act_mem_we) begin
      check("we_without_ack", 1, 0);
    end
  end

  task automatic push(input bit host, input logic [11:0] a, input logic [7:0] d);
    exp_t e;
    e.host = host; e.addr = a; e.data = d; e.we = (a < 12'hF80);
    sb_q.push_back(e);
  endtask

  // Single write; called at posedge+1, returns at posedge+1 after the ack cycle.
  task automatic do_wr(input bit host, input logic [11:0] a, input logic [7:0] d);
    int c;
    push(host, a, d);
    if (host) begin host_mem_wr = 1; host_mem_wr_addr = a; host_mem_wr_data = d; end
    else      begin hw_mem_wr = 1;   hw_mem_wr_addr = a;   hw_mem_wr_data = d;   end
    for (c = 0; c < 4; c++) begin
      @(negedge clk);
      if (host ? host_mem_wr_ack_p : hw_mem_wr_ack_p) break;
    end
    check("req_to_ack_latency", c, 1);
    @(posedge clk); #1;
    hw_mem_wr = 0; host_mem_wr = 0;
  endtask

  initial begin
    int hc, sc, nhw;
    bit hd, sd;
    rst = 1; hw_mem_wr = 0; host_mem_wr = 0; wr_cnt_clr = 0; w_hw = 0;
    hw_mem_wr_addr = 0; hw_mem_wr_data = 0; host_mem_wr_addr = 0; host_mem_wr_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_hw_ack",   {31'd0, hw_mem_wr_ack_p}, 0);
    check("rst_host_ack", {31'd0, host_mem_wr_ack_p}, 0);
    check("rst_we",       {31'd0, act_mem_we}, 0);
    check("rst_addr_err", {31'd0, addr_err}, 0);
    check("rst_wr_cnt",   {16'd0, wr_cnt}, 0);
    check("rst_mem_addr", {20'd0, act_mem_addr}, 0);

    // single NPU write
    do_wr(0, 12'h100, 8'h5A);
    check("wr_cnt_after_first", {16'd0, wr_cnt}, 1);
    check("addr_hold", {20'd0, act_mem_addr}, 32'h100);
    check("data_hold", {24'd0, act_mem_wdata}, 32'h5A);
    do_wr(1, 12'h3FF, 8'hC3);
    check("wr_cnt_host", {16'd0, wr_cnt}, 2);

    // simultaneous requests: hw first, host two cycles later
    push(0, 12'h010, 8'h11);
    push(1, 12'h020, 8'h22);
    hw_mem_wr = 1; hw_mem_wr_addr = 12'h010; hw_mem_wr_data = 8'h11;
    host_mem_wr = 1; host_mem_wr_addr = 12'h020; host_mem_wr_data = 8'h22;
    hd = 0; sd = 0; hc = -1; sc = -1;
    for (int c = 0; c < 10 && !(hd && sd); c++) begin
      @(negedge clk);
      if (hw_mem_wr_ack_p)   begin hd = 1; hc = c; end
      if (host_mem_wr_ack_p) begin sd = 1; sc = c; end
      @(posedge clk); #1;
      if (hd) hw_mem_wr = 0;
      if (sd) host_mem_wr = 0;
    end
    check("both_hw_ack_cycle", hc, 1);
    check("both_host_ack_cycle", sc, 3);
    check("wr_cnt_both", {16'd0, wr_cnt}, 4);

    // hw held continuously: host forced through by starvation limit
    for (int i = 0; i < 8; i++) push(0, 12'h030, 8'h33);
    push(1, 12'h040, 8'h44);
    hw_mem_wr = 1; hw_mem_wr_addr = 12'h030; hw_mem_wr_data = 8'h33;
    host_mem_wr = 1; host_mem_wr_addr = 12'h040; host_mem_wr_data = 8'h44;
    sd = 0; sc = 99; nhw = 0;
    for (int c = 0; c < 40 && !sd; c++) begin
      @(negedge clk);
      if (hw_mem_wr_ack_p) nhw++;
      if (host_mem_wr_ack_p) begin sd = 1; sc = c; end
      @(posedge clk); #1;
    end
    hw_mem_wr = 0; host_mem_wr = 0;
    check("starve_bound", {31'd0, sc <= LIMIT + 2}, 1);
    check("starve_ack_cycle", sc, LIMIT + 1);
    check("starve_hw_acks", nhw, 8);
    check("wr_cnt_starve", {16'd0, wr_cnt}, 13);

    // out-of-range addresses
    do_wr(1, 12'hF80, 8'h77);
    check("oor_wr_cnt", {16'd0, wr_cnt}, 13);
    check("oor_addr_err", {31'd0, addr_err}, 1);
    do_wr(0, 12'hF7F, 8'h78);
    check("last_valid_wr_cnt", {16'd0, wr_cnt}, 14);
    check("addr_err_sticky", {31'd0, addr_err}, 1);
    do_wr(0, 12'hFFF, 8'h79);
    check("oor_hw_wr_cnt", {16'd0, wr_cnt}, 14);

    // clear coincident with a write
    push(0, 12'h050, 8'h55);
    hw_mem_wr = 1; hw_mem_wr_addr = 12'h050; hw_mem_wr_data = 8'h55;
    @(negedge clk);
    @(negedge clk);
    check("clr_write_we", {31'd0, act_mem_we}, 1);
    wr_cnt_clr = 1;
    @(posedge clk); #1;
    wr_cnt_clr = 0; hw_mem_wr = 0;
    check("clr_priority", {16'd0, wr_cnt}, 0);
    do_wr(0, 12'h051, 8'h56);
    check("cnt_after_clr", {16'd0, wr_cnt}, 1);

    // reset during the ACK cycle
    hw_mem_wr = 1; hw_mem_wr_addr = 12'h0AA; hw_mem_wr_data = 8'hBB;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    check("rst_in_ack_no_ack", {31'd0, hw_mem_wr_ack_p}, 0);
    check("rst_in_ack_no_we",  {31'd0, act_mem_we}, 0);
    @(posedge clk); #1;
    rst = 0;
    push(0, 12'h0AA, 8'hBB);
    @(negedge clk);
    check("post_rst_no_ack", {31'd0, hw_mem_wr_ack_p}, 0);
    check("post_rst_addr",   {20'd0, act_mem_addr}, 0);
    check("post_rst_wr_cnt", {16'd0, wr_cnt}, 0);
    check("post_rst_addr_err", {31'd0, addr_err}, 0);
    hd = 0;
    for (int c = 0; c < 4 && !hd; c++) begin
      @(negedge clk);
      if (hw_mem_wr_ack_p) begin hd = 1; check("post_rst_latency", c, 0); end
    end
    if (!hd) check("post_rst_ack_timeout", 0, 1);
    @(posedge clk); #1;
    hw_mem_wr = 0;
    check("post_rst_cnt", {16'd0, wr_cnt}, 1);

    // counter wrap on the narrow instance
    w_hw = 1; nhw = 0;
    for (int c = 0; c < 60 && nhw < 15; c++) begin
      @(negedge clk);
      if (w_hw_ack) nhw++;
    end
    @(posedge clk); #1;
    w_hw = 0;
    check("wrap_pre_max", {28'd0, w_cnt}, 15);
    w_hw = 1; hd = 0;
    for (int c = 0; c < 4 && !hd; c++) begin
      @(negedge clk);
      if (w_hw_ack) hd = 1;
    end
    @(posedge clk); #1;
    w_hw = 0;
    check("wrap_ack_seen", {31'd0, hd}, 1);
    check("wrap_to_zero", {28'd0, w_cnt}, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
